// File: rtl/ccff_bitstream_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_loader_pkg
//  Description : Shared types and width helpers for the CCFF bitstream loader
//                (FSM state encoding, counter/index widths, final-word size).
//  Revision    : 1.0 - initial release
// ============================================================================
package ccff_loader_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_WORD_W    = 32;
    localparam int DEF_CHAIN_LEN = 1024;

    // Width of a counter that must hold 0..chain_len inclusive
    function automatic int cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

    // Width of the bit index inside one bitstream word
    function automatic int idx_width(input int word_w);
        return (word_w > 1) ? $clog2(word_w) : 1;
    endfunction

    // Number of valid bits carried by the final word of a load
    function automatic int last_word_bits(input int chain_len, input int word_w);
        return ((chain_len - 1) % word_w) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ccff_bitstream_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_bitstream_loader_if
//  Description : Valid/ready bitstream word stream feeding the CCFF loader.
//                master = bitstream source (DMA/host), slave = loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ccff_bitstream_loader_if #(
    parameter int WORD_W = 32
) ();
    logic              s_valid;
    logic [WORD_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface
`default_nettype wire

// File: rtl/ccff_bitstream_loader_readback_packer.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_readback_packer
//  Description : Serial-to-word packer for chain readback. Bits arrive LSB
//                first; a word is emitted when full or when the final bit of
//                a load is flagged (high bits zero-padded). Only instantiated
//                when CCFF_READBACK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccff_readback_packer
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               i_clear,
    input  wire               i_shift,
    input  wire               i_bit,
    input  wire               i_last,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data
);
    localparam int IDX_W = idx_width(WORD_W);
    localparam logic [IDX_W-1:0] c_pos_max = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] r_pack;
    logic [IDX_W-1:0]  r_pos;
    logic [WORD_W-1:0] w_merged;

    assign w_merged = r_pack | (WORD_W'(i_bit) << r_pos);

    // Pack incoming tail bits and emit a word when full or at end of load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pack  <= '0;
            r_pos   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= 1'b0;
            if (i_clear) begin
                r_pack <= '0;
                r_pos  <= '0;
            end else if (i_shift) begin
                if ((r_pos == c_pos_max) || i_last) begin
                    o_valid <= 1'b1;
                    o_data  <= w_merged;
                    r_pack  <= '0;
                    r_pos   <= '0;
                end else begin
                    r_pack <= w_merged;
                    r_pos  <= r_pos + 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_bitstream_loader
//  Description : Programming-side driver for one CCFF region. Takes bitstream
//                words over a valid/ready stream, shifts exactly CHAIN_LEN
//                bits (LSB first) onto ccff_head with a shift qualifier, and
//                pulses done. Word boundaries are prefetched for zero-bubble
//                streaming. Optional readback of the old chain contents via
//                ccff_tail is enabled by defining CCFF_READBACK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter  int WORD_W    = DEF_WORD_W,
    parameter  int CHAIN_LEN = DEF_CHAIN_LEN,
    localparam int CNT_W     = cnt_width(CHAIN_LEN)
) (
    input  wire                     prog_clk,
    input  wire                     pReset,
    input  wire                     start,
    ccff_bitstream_loader_if.slave  s_if,
    output logic                    ccff_head,
    output logic                    ccff_shift_en,
    output logic                    busy,
    output logic                    done,
`ifdef CCFF_READBACK_EN
    input  wire                     ccff_tail,
    output logic                    rb_valid,
    output logic [WORD_W-1:0]       rb_data,
`endif
    output logic [CNT_W-1:0]        bits_shifted
);
    localparam int IDX_W = idx_width(WORD_W);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] c_idx_max  = IDX_W'(WORD_W - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [WORD_W-1:0] r_sreg;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_cnt;

    logic w_ready;
    logic w_hs;
    logic w_load_clr;
    logic w_last_bit;
    logic w_word_end;

    // The bit being shifted this cycle is the final one of the chain
    assign w_last_bit   = (r_cnt == c_last_cnt);
    assign w_word_end   = (r_idx == c_idx_max);
    assign w_hs         = w_ready & s_if.s_valid;
    assign s_if.s_ready = w_ready;
    assign bits_shifted = r_cnt;

    // FSM state register
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and outputs; ready is raised during the last bit of a word
    // (prefetch) only when more chain bits remain, so no extra word is taken
    always_comb begin
        w_state_nxt   = r_state;
        w_ready       = 1'b0;
        w_load_clr    = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load_clr  = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                busy    = 1'b1;
                w_ready = 1'b1;
                if (s_if.s_valid) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy          = 1'b1;
                ccff_shift_en = 1'b1;
                ccff_head     = r_sreg[0];
                if (w_last_bit) begin
                    w_state_nxt = DONE;
                end else if (w_word_end) begin
                    w_ready     = 1'b1;
                    w_state_nxt = s_if.s_valid ? SHIFT : FETCH;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Shift register, in-word bit index and chain bit counter
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_sreg <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_load_clr) begin
                r_cnt <= '0;
            end else if (ccff_shift_en) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_hs) begin
                r_sreg <= s_if.s_data;
                r_idx  <= '0;
            end else if (ccff_shift_en) begin
                r_sreg <= r_sreg >> 1;
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

`ifdef CCFF_READBACK_EN
    ccff_readback_packer #(
        .WORD_W (WORD_W)
    ) u_readback (
        .clk     (prog_clk),
        .rst     (pReset),
        .i_clear (w_load_clr),
        .i_shift (ccff_shift_en),
        .i_bit   (ccff_tail),
        .i_last  (ccff_shift_en & w_last_bit),
        .o_valid (rb_valid),
        .o_data  (rb_data)
    );
`endif

endmodule
`default_nettype wire
